// File: rtl/cdb_result_buffer_pkg.sv
// Shared types for the CDB result path: the result payload broadcast on the
// common data bus and the default per-unit result buffer depth.
package cdb_result_buffer_pkg;

   // Default number of result entries held per execution unit
   localparam int CDB_BUF_DEPTH = 2;

   // Result payload carried from a functional unit onto the CDB
   typedef struct packed {
      logic [5:0]  robTag;
      logic [31:0] value;
      logic        exception;
   } cdb_t;

endpackage

// File: rtl/cdb_result_buffer.sv
// Per-execution-unit result queue in front of the CDB arbiter.
// Holds completed results in arrival order, requests the CDB with the oldest
// one and retires it on grant; back-pressures the FU when full.
// Optional feature macro: CDB_BUF_BYPASS_EN (zero-latency bypass when empty).
module cdb_result_buffer
   import cdb_result_buffer_pkg::*;
#(
   parameter int DEPTH = CDB_BUF_DEPTH
) (
   input  logic clk,
   input  logic rst_n,
   input  logic flush,
   input  logic fu_valid,
   input  cdb_t fu_data,
   output logic fu_ready,
   output logic cdb_req,
   output cdb_t cdb_data,
   input  logic cdb_grant
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = $clog2(DEPTH + 1);

   logic [CNT_W-1:0] r_count;
   logic [PTR_W-1:0] r_rdPtr;
   logic [PTR_W-1:0] r_wrPtr;
   cdb_t             r_mem [DEPTH];

   logic             w_empty;
   logic             w_full;
   logic             w_bypass;
   logic             w_push;
   logic             w_pop;
   logic [CNT_W-1:0] w_countNext;

   // Decide whether an incoming result can skip storage and go straight to the CDB
   always_comb begin
      w_empty  = (r_count == '0);
      w_full   = (r_count == CNT_W'(DEPTH));
      w_bypass = 1'b0;
`ifdef CDB_BUF_BYPASS_EN
      w_bypass = w_empty && fu_valid && !flush;
`endif
   end

   // Drive the FU handshake and the CDB request; everything is quiet while in reset
   always_comb begin
      fu_ready = rst_n && !w_full;
      cdb_req  = rst_n && (!w_empty || w_bypass);
      cdb_data = '0;
      if (rst_n) begin
         if (!w_empty) begin
            cdb_data = r_mem[r_rdPtr];
         end else if (w_bypass) begin
            cdb_data = fu_data;
         end
      end
   end

   // Work out this cycle's push/pop and the resulting occupancy; a bypassed
   // result that is granted immediately never needs a slot
   always_comb begin
      w_push      = fu_valid && fu_ready && !flush && !(w_bypass && cdb_grant);
      w_pop       = cdb_req && cdb_grant && !w_empty && !flush;
      w_countNext = r_count;
      if (w_push && !w_pop) begin
         w_countNext = r_count + CNT_W'(1);
      end else if (w_pop && !w_push) begin
         w_countNext = r_count - CNT_W'(1);
      end
   end

   // Pointers and occupancy; reset and flush both return the queue to empty
   always_ff @(posedge clk) begin
      if (!rst_n || flush) begin
         r_count <= '0;
         r_rdPtr <= '0;
         r_wrPtr <= '0;
      end else begin
         r_count <= w_countNext;
         if (w_push) begin
            r_wrPtr <= r_wrPtr + PTR_W'(1);
         end
         if (w_pop) begin
            r_rdPtr <= r_rdPtr + PTR_W'(1);
         end
      end
   end

   // Result storage; contents are only meaningful where the pointers say so
   always_ff @(posedge clk) begin
      if (w_push) begin
         r_mem[r_wrPtr] <= fu_data;
      end
   end

endmodule

// File: tb/tb_cdb_result_buffer.sv
// Self-checking bench for cdb_result_buffer.
// A queue-based reference model predicts fu_ready/cdb_req/cdb_data every cycle;
// directed scenarios add literal expectations on the order results reach the CDB.
// Honours CDB_BUF_BYPASS_EN the same way the design does.
module tb_cdb_result_buffer;
   import cdb_result_buffer_pkg::*;

   localparam int DEPTH = CDB_BUF_DEPTH;

   logic clk = 1'b0;
   logic rst_n;
   logic flush;
   logic fu_valid;
   cdb_t fu_data;
   logic fu_ready;
   logic cdb_req;
   cdb_t cdb_data;
   logic cdb_grant;

   int   nChecks = 0;
   int   nFails  = 0;
   bit   compareOn = 1'b1;

   cdb_t modelQ[$];
   cdb_t emitted[$];

   cdb_result_buffer #(.DEPTH(DEPTH)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .flush     (flush),
      .fu_valid  (fu_valid),
      .fu_data   (fu_data),
      .fu_ready  (fu_ready),
      .cdb_req   (cdb_req),
      .cdb_data  (cdb_data),
      .cdb_grant (cdb_grant)
   );

   // Free-running clock, 10 time units per cycle
   always #5 clk = ~clk;

   function automatic cdb_t mk(input int tag);
      cdb_t r;
      r.robTag    = 6'(tag);
      r.value     = 32'h1000_0000 + 32'(tag * 17);
      r.exception = tag[0];
      return r;
   endfunction

   task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
      nChecks++;
      if (actual !== expected) begin
         nFails++;
         $display("[TB] FAIL %s actual=%h expected=%h at t=%0t", name, actual, expected, $time);
      end
   endtask

   task automatic applyStimulus(input logic rstN, input logic fl, input logic valid,
                                input cdb_t data, input logic grant);
      rst_n     = rstN;
      flush     = fl;
      fu_valid  = valid;
      fu_data   = data;
      cdb_grant = grant;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Model: would the FU's result go straight out this cycle?
   function automatic bit modelBypass();
`ifdef CDB_BUF_BYPASS_EN
      return rst_n && (modelQ.size() == 0) && fu_valid && !flush;
`else
      return 1'b0;
`endif
   endfunction

   // Mid-cycle compare of every output against the model, plus a log of what
   // actually went out on the CDB
   always @(negedge clk) begin
      if (compareOn) begin
         logic expReady;
         logic expReq;
         cdb_t expData;
         expReady = rst_n && (modelQ.size() < DEPTH);
         expReq   = rst_n && ((modelQ.size() != 0) || modelBypass());
         expData  = '0;
         if (rst_n && modelQ.size() != 0) expData = modelQ[0];
         else if (modelBypass())          expData = fu_data;
         checkOutput("fu_ready", 64'(fu_ready), 64'(expReady));
         checkOutput("cdb_req", 64'(cdb_req), 64'(expReq));
         checkOutput("cdb_data", 64'(cdb_data), 64'(expData));
         if (rst_n && cdb_req && cdb_grant) emitted.push_back(cdb_data);
      end
   end

   // Model state update at each edge: reset/flush empty it, otherwise the head
   // leaves on grant and an accepted result joins the tail
   always @(posedge clk) begin
      if (!rst_n || flush) begin
         modelQ.delete();
      end else begin
         bit doPop;
         bit doPush;
         doPop  = (modelQ.size() != 0) && cdb_grant;
         doPush = fu_valid && (modelQ.size() < DEPTH) && !(modelBypass() && cdb_grant);
         if (doPop) void'(modelQ.pop_front());
         if (doPush) modelQ.push_back(fu_data);
      end
   end

   initial begin
      int base;
      int sent;
      int cycles;
      cdb_t items[10];

      // Reset held for two cycles with an eager FU
      applyStimulus(1'b0, 1'b0, 1'b1, mk(1), 1'b0);
      tick();
      tick();
      applyStimulus(1'b1, 1'b0, 1'b0, '0, 1'b0);
      #2;
      checkOutput("reset_req", 64'(cdb_req), 64'd0);
      checkOutput("reset_ready", 64'(fu_ready), 64'd1);
      tick();

      // Fill to full, hold off the third result, then drain in order
      base = emitted.size();
      applyStimulus(1'b1, 1'b0, 1'b1, mk(10), 1'b0);
      tick();
      applyStimulus(1'b1, 1'b0, 1'b1, mk(11), 1'b0);
      tick();
      checkOutput("full_ready", 64'(fu_ready), 64'd0);
      applyStimulus(1'b1, 1'b0, 1'b1, mk(12), 1'b0);
      tick();
      checkOutput("held_ready", 64'(fu_ready), 64'd0);
      applyStimulus(1'b1, 1'b0, 1'b1, mk(12), 1'b1);
      tick();
      applyStimulus(1'b1, 1'b0, 1'b1, mk(12), 1'b1);
      tick();
      applyStimulus(1'b1, 1'b0, 1'b0, '0, 1'b1);
      tick();
      applyStimulus(1'b1, 1'b0, 1'b0, '0, 1'b0);
      checkOutput("fill_count", 64'(emitted.size() - base), 64'd3);
      if (emitted.size() - base == 3) begin
         checkOutput("fill_order0", 64'(emitted[base]),   64'(mk(10)));
         checkOutput("fill_order1", 64'(emitted[base+1]), 64'(mk(11)));
         checkOutput("fill_order2", 64'(emitted[base+2]), 64'(mk(12)));
      end
      tick();

      // Push and pop together with one entry held
      base = emitted.size();
      applyStimulus(1'b1, 1'b0, 1'b1, mk(20), 1'b0);
      tick();
      applyStimulus(1'b1, 1'b0, 1'b1, mk(21), 1'b1);
      tick();
      applyStimulus(1'b1, 1'b0, 1'b0, '0, 1'b0);
      #1;
      checkOutput("pp_req", 64'(cdb_req), 64'd1);
      checkOutput("pp_head", 64'(cdb_data), 64'(mk(21)));
      checkOutput("pp_ready", 64'(fu_ready), 64'd1);
      checkOutput("pp_first_out", 64'(emitted[emitted.size()-1]), 64'(mk(20)));
      applyStimulus(1'b1, 1'b0, 1'b0, '0, 1'b1);
      tick();
      applyStimulus(1'b1, 1'b0, 1'b0, '0, 1'b0);
      checkOutput("pp_count", 64'(emitted.size() - base), 64'd2);
      tick();

      // Flush while full, with a new result and a grant in the same cycle
      applyStimulus(1'b1, 1'b0, 1'b1, mk(30), 1'b0);
      tick();
      applyStimulus(1'b1, 1'b0, 1'b1, mk(31), 1'b0);
      tick();
      base = emitted.size();
      applyStimulus(1'b1, 1'b1, 1'b1, mk(32), 1'b1);
      tick();
      applyStimulus(1'b1, 1'b0, 1'b0, '0, 1'b0);
      #1;
      checkOutput("flush_req", 64'(cdb_req), 64'd0);
      checkOutput("flush_ready", 64'(fu_ready), 64'd1);
      checkOutput("flush_bcast", 64'(emitted.size() - base), 64'd1);
      checkOutput("flush_head", 64'(emitted[emitted.size()-1]), 64'(mk(30)));
      tick();
      checkOutput("flush_lost", 64'(cdb_req), 64'd0);

      // Ten results streamed with an alternating grant; pointers wrap several times
      for (int i = 0; i < 10; i++) items[i] = mk(40 + i);
      base   = emitted.size();
      sent   = 0;
      cycles = 0;
      while ((emitted.size() - base < 10) && cycles < 200) begin
         logic accept;
         applyStimulus(1'b1, 1'b0, sent < 10, (sent < 10) ? items[sent] : '0, cycles[0] == 1'b0);
         #1;
         accept = fu_ready && (sent < 10);
         tick();
         if (accept) sent++;
         cycles++;
      end
      applyStimulus(1'b1, 1'b0, 1'b0, '0, 1'b0);
      checkOutput("wrap_count", 64'(emitted.size() - base), 64'd10);
      if (emitted.size() - base == 10) begin
         for (int i = 0; i < 10; i++) checkOutput($sformatf("wrap_order%0d", i), 64'(emitted[base+i]), 64'(items[i]));
      end
      tick();

      // Empty buffer, result arriving with a grant, then without one
`ifdef CDB_BUF_BYPASS_EN
      applyStimulus(1'b1, 1'b0, 1'b1, mk(50), 1'b1);
      #2;
      checkOutput("byp_req", 64'(cdb_req), 64'd1);
      checkOutput("byp_data", 64'(cdb_data), 64'(mk(50)));
      tick();
      applyStimulus(1'b1, 1'b0, 1'b0, '0, 1'b0);
      #1;
      checkOutput("byp_not_stored", 64'(cdb_req), 64'd0);
      tick();
      applyStimulus(1'b1, 1'b0, 1'b1, mk(51), 1'b0);
      #2;
      checkOutput("byp_req_nogrant", 64'(cdb_req), 64'd1);
      tick();
      applyStimulus(1'b1, 1'b0, 1'b0, '0, 1'b0);
      #1;
      checkOutput("byp_stored_req", 64'(cdb_req), 64'd1);
      checkOutput("byp_stored_data", 64'(cdb_data), 64'(mk(51)));
`else
      applyStimulus(1'b1, 1'b0, 1'b1, mk(50), 1'b1);
      #2;
      checkOutput("nobyp_req", 64'(cdb_req), 64'd0);
      tick();
      applyStimulus(1'b1, 1'b0, 1'b0, '0, 1'b0);
      #1;
      checkOutput("nobyp_next_req", 64'(cdb_req), 64'd1);
      checkOutput("nobyp_next_data", 64'(cdb_data), 64'(mk(50)));
`endif
      applyStimulus(1'b1, 1'b0, 1'b0, '0, 1'b1);
      tick();
      applyStimulus(1'b1, 1'b0, 1'b0, '0, 1'b0);
      tick();
      checkOutput("final_idle", 64'(cdb_req), 64'd0);

      compareOn = 1'b0;
      $display("TB_RESULT checks=%0d failures=%0d", nChecks, nFails);
      $finish;
   end

endmodule
